// File: rtl/occ_pattern_pkg.sv
// Shared OCC framed counter pattern definitions, used by the TX generator and RX checker.
package occ_pattern_pkg;

  localparam logic [15:0] COMMA_WORD     = 16'hBC95;
  localparam logic [1:0]  COMMA_CHARISK  = 2'b10;
  localparam int          FRAME_LEN_LOG2 = 5;

  // Checker state encoding
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SEED   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // One RX word as carried through the checker pipeline; code_err folds
  // all disparity and not-in-table flags into a single bit.
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  charisk;
    logic        code_err;
  } rx_word_t;

endpackage

// File: rtl/occ_rx_pattern_checker_if.sv
// RX parallel word bus from the transceiver tile to the pattern checker.
interface occ_rx_pattern_checker_if;
  logic [15:0] rxdata;
  logic [1:0]  rxcharisk;
  logic [1:0]  rxdisperr;
  logic [1:0]  rxnotintable;

  modport master (output rxdata, output rxcharisk, output rxdisperr, output rxnotintable);
  modport slave  (input  rxdata, input  rxcharisk, input  rxdisperr, input  rxnotintable);
endinterface

// File: rtl/occ_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module occ_sat_counter #(
  parameter int g_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [g_WIDTH-1:0] cnt_o
);

  logic [g_WIDTH-1:0] cnt_reg;

  // Count up, hold at all-ones, clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (inc_i && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + g_WIDTH'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/occ_rx_pattern_checker.sv
// RX checker for the OCC framed counter pattern: frame lock, word prediction, statistics.
module occ_rx_pattern_checker
  import occ_pattern_pkg::*;
#(
  parameter logic [15:0] g_COMMA_WORD     = COMMA_WORD,
  parameter logic [1:0]  g_COMMA_CHARISK  = COMMA_CHARISK,
  parameter int          g_FRAME_LEN_LOG2 = FRAME_LEN_LOG2,
  parameter int          g_LOSS_THRESHOLD = 4,
  parameter int          g_CNT_WIDTH      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  occ_rx_pattern_checker_if.slave rx,
  output logic                   locked_o,
  output logic                   err_o,
  output logic [g_CNT_WIDTH-1:0] err_cnt_o,
  output logic [g_CNT_WIDTH-1:0] code_err_cnt_o,
  output logic [g_CNT_WIDTH-1:0] word_cnt_o,
  output logic [15:0]            lock_loss_cnt_o
);

  localparam int L = g_FRAME_LEN_LOG2;

  rx_word_t    s1_word_reg, s2_word_reg;
  logic        s1_valid_reg, s2_valid_reg;
  logic [1:0]  state_reg, state_next;
  logic [15:0] exp_reg, exp_next;
  logic [7:0]  bad_reg, bad_next, bad_inc;
  logic        err_reg, err_next;
  logic        inc_err, inc_code, inc_word, inc_loss;
  logic        is_comma, comma_slot, word_match;

  assign is_comma   = (s2_word_reg.charisk == g_COMMA_CHARISK) && (s2_word_reg.data == g_COMMA_WORD);
  assign comma_slot = (exp_reg[L-1:0] == '0);
  assign word_match = !s2_word_reg.code_err &&
                      (comma_slot ? is_comma
                                  : ((s2_word_reg.charisk == 2'b00) && (s2_word_reg.data == exp_reg)));
  assign bad_inc    = bad_reg + 8'd1;

  // Two-stage input pipeline; a valid bit survives only while en_i stays high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_word_reg  <= '0;
      s2_word_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_word_reg  <= '{data: rx.rxdata, charisk: rx.rxcharisk,
                        code_err: (|rx.rxdisperr) | (|rx.rxnotintable)};
      s2_word_reg  <= s1_word_reg;
      s1_valid_reg <= en_i;
      s2_valid_reg <= s1_valid_reg & en_i;
    end
  end

  // Lock FSM and word prediction on the stage-2 word
  always_comb begin
    state_next = state_reg;
    exp_next   = exp_reg;
    bad_next   = bad_reg;
    err_next   = 1'b0;
    inc_err    = 1'b0;
    inc_code   = 1'b0;
    inc_word   = 1'b0;
    inc_loss   = 1'b0;
    if (!en_i) begin
      state_next = ST_HUNT;
      bad_next   = '0;
    end else if (s2_valid_reg) begin
      inc_code = s2_word_reg.code_err;
      case (state_reg)
        ST_HUNT: begin
          if (is_comma) state_next = ST_SEED;
        end
        ST_SEED: begin
          if ((s2_word_reg.charisk == 2'b00) && (s2_word_reg.data[L-1:0] == L'(1))) begin
            exp_next   = s2_word_reg.data + 16'd1;
            bad_next   = '0;
            state_next = ST_LOCKED;
          end else if (!is_comma) begin
            state_next = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // The comma slot also consumes a counter value, so exp always advances
          exp_next = exp_reg + 16'd1;
          inc_word = 1'b1;
          if (word_match) begin
            bad_next = '0;
          end else begin
            err_next = 1'b1;
            inc_err  = 1'b1;
            if (bad_inc >= 8'(g_LOSS_THRESHOLD)) begin
              bad_next   = '0;
              state_next = ST_HUNT;
              inc_loss   = 1'b1;
            end else begin
              bad_next = bad_inc;
            end
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  // FSM state, prediction and error pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_HUNT;
      exp_reg   <= '0;
      bad_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      exp_reg   <= exp_next;
      bad_reg   <= bad_next;
      err_reg   <= err_next;
    end
  end

  assign locked_o = (state_reg == ST_LOCKED);
  assign err_o    = err_reg;

  logic [2:0]             inc_vec;
  logic [g_CNT_WIDTH-1:0] cnt_arr [3];

  assign inc_vec = {inc_word, inc_code, inc_err};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat_cnt
    occ_sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_cnt (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (clear_i),
      .inc_i  (inc_vec[gi]),
      .cnt_o  (cnt_arr[gi])
    );
  end

  assign err_cnt_o      = cnt_arr[0];
  assign code_err_cnt_o = cnt_arr[1];
  assign word_cnt_o     = cnt_arr[2];

  occ_sat_counter #(.g_WIDTH(16)) u_loss_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (clear_i),
    .inc_i  (inc_loss),
    .cnt_o  (lock_loss_cnt_o)
  );

endmodule

// File: tb/tb_occ_rx_pattern_checker.sv
// Bench for occ_rx_pattern_checker: directed pattern streams, reference model, per-cycle compare.
module tb_occ_rx_pattern_checker;

  localparam int     CW    = 32;
  localparam int     FRAME = 32;
  localparam int     THR   = 4;
  localparam longint MAXW  = (64'd1 << CW) - 1;
  localparam longint MAXL  = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;

  occ_rx_pattern_checker_if rxif();

  logic          locked, err;
  logic [CW-1:0] err_cnt, code_cnt, word_cnt;
  logic [15:0]   loss_cnt;

  occ_rx_pattern_checker dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .en_i           (en),
    .clear_i        (clr),
    .rx             (rxif),
    .locked_o       (locked),
    .err_o          (err),
    .err_cnt_o      (err_cnt),
    .code_err_cnt_o (code_cnt),
    .word_cnt_o     (word_cnt),
    .lock_loss_cnt_o(loss_cnt)
  );

  // Standalone saturating counter, narrow enough to reach all-ones
  logic       s_inc = 1'b0;
  logic       s_clr = 1'b0;
  logic [2:0] s_cnt;

  occ_sat_counter #(.g_WIDTH(3)) u_sat (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .clr_i  (s_clr),
    .inc_i  (s_inc),
    .cnt_o  (s_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic tb_comma(input logic [15:0] d, input logic [1:0] k);
    return (k == 2'b10) && (d == 16'hBC95);
  endfunction

  // Reference model: state of the link as a receiver would describe it
  int     m_state = 0;      // 0 hunting, 1 saw comma, 2 locked
  int     m_exp = 0;
  int     m_bad = 0;
  logic   m_locked = 1'b0;
  logic   m_err = 1'b0;
  longint m_err_cnt = 0, m_code = 0, m_word = 0, m_loss = 0;
  logic        h1_v = 1'b0, h2_v = 1'b0;
  logic [15:0] h1_d = '0, h2_d = '0;
  logic [1:0]  h1_k = '0, h2_k = '0;
  logic        h1_c = 1'b0, h2_c = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int st, ex, bd;
    logic e, proc, good, ie, ic, iw, il;
    longint ec, cc, wc, lc;
    if (!rst_n) begin
      m_state <= 0; m_exp <= 0; m_bad <= 0; m_locked <= 1'b0; m_err <= 1'b0;
      m_err_cnt <= 0; m_code <= 0; m_word <= 0; m_loss <= 0;
      h1_v <= 1'b0; h2_v <= 1'b0;
    end else begin
      st = m_state; ex = m_exp; bd = m_bad;
      e = 1'b0; ie = 1'b0; ic = 1'b0; iw = 1'b0; il = 1'b0;
      // a word is judged two edges after capture, if enable held throughout
      proc = en && h1_v && h2_v;
      if (!en) begin
        st = 0; bd = 0;
      end else if (proc) begin
        ic = h2_c;
        if (st == 0) begin
          if (tb_comma(h2_d, h2_k)) st = 1;
        end else if (st == 1) begin
          if (h2_k == 2'b00 && (int'(h2_d) % FRAME) == 1) begin
            ex = (int'(h2_d) + 1) % 65536; st = 2; bd = 0;
          end else if (!tb_comma(h2_d, h2_k)) begin
            st = 0;
          end
        end else begin
          if ((ex % FRAME) == 0) good = !h2_c && tb_comma(h2_d, h2_k);
          else                   good = !h2_c && h2_k == 2'b00 && int'(h2_d) == ex;
          ex = (ex + 1) % 65536;
          iw = 1'b1;
          if (good) bd = 0;
          else begin
            e = 1'b1; ie = 1'b1; bd = bd + 1;
            if (bd >= THR) begin st = 0; bd = 0; il = 1'b1; end
          end
        end
      end
      ec = m_err_cnt; cc = m_code; wc = m_word; lc = m_loss;
      if (clr) begin
        ec = 0; cc = 0; wc = 0; lc = 0;
      end else begin
        if (ie && ec < MAXW) ec = ec + 1;
        if (ic && cc < MAXW) cc = cc + 1;
        if (iw && wc < MAXW) wc = wc + 1;
        if (il && lc < MAXL) lc = lc + 1;
      end
      m_state <= st; m_exp <= ex; m_bad <= bd;
      m_locked <= (st == 2); m_err <= e;
      m_err_cnt <= ec; m_code <= cc; m_word <= wc; m_loss <= lc;
      h2_v <= h1_v; h2_d <= h1_d; h2_k <= h1_k; h2_c <= h1_c;
      h1_v <= en; h1_d <= rxif.rxdata; h1_k <= rxif.rxcharisk;
      h1_c <= (|rxif.rxdisperr) | (|rxif.rxnotintable);
    end
  end

  // Per-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("locked", 64'(locked), 64'(m_locked));
      chk("err", 64'(err), 64'(m_err));
      chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
      chk("code_err_cnt", 64'(code_cnt), 64'(m_code));
      chk("word_cnt", 64'(word_cnt), 64'(m_word));
      chk("lock_loss_cnt", 64'(loss_cnt), 64'(m_loss));
    end
  end

  logic [15:0] c = '0;

  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de,
                       input logic [1:0] nt, input logic e, input logic cl);
    @(negedge clk);
    rxif.rxdata = d; rxif.rxcharisk = k; rxif.rxdisperr = de; rxif.rxnotintable = nt;
    en = e; clr = cl;
    @(posedge clk);
  endtask

  task automatic send_c(input logic [15:0] v, input logic e, input logic cl);
    if (v[4:0] == 5'd0) drive(16'hBC95, 2'b10, 2'b00, 2'b00, e, cl);
    else                drive(v, 2'b00, 2'b00, 2'b00, e, cl);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      send_c(c, 1'b1, 1'b0);
      c = c + 16'd1;
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_locked"}, 64'(locked), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 0);
    chk({tag, "_code_cnt"}, 64'(code_cnt), 0);
    chk({tag, "_word_cnt"}, 64'(word_cnt), 0);
    chk({tag, "_loss_cnt"}, 64'(loss_cnt), 0);
  endtask

  initial begin
    rxif.rxdata = '0; rxif.rxcharisk = '0; rxif.rxdisperr = '0; rxif.rxnotintable = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1 all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    $display("txn reset: outputs checked");

    // clean stream, lock two cycles after seed 0x0001
    c = 16'h0000;
    stream(3);
    #1 chk("lock_early", 64'(locked), 0);
    stream(1);
    #1 chk("lock_rise", 64'(locked), 1);
    stream(1000);
    #1 chk("clean_err_cnt", 64'(err_cnt), 0);
    chk("clean_word_cnt", 64'(word_cnt), 1000);
    chk("clean_loss_cnt", 64'(loss_cnt), 0);
    $display("txn clean: word_cnt=%0d err_cnt=%0d", word_cnt, err_cnt);

    // disparity error on one locked word
    stream(6);
    drive(c, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0); c = c + 16'd1;
    stream(2);
    #1 chk("disp_code_cnt", 64'(code_cnt), 1);
    chk("disp_err_cnt", 64'(err_cnt), 1);
    chk("disp_word_cnt", 64'(word_cnt), 1009);
    chk("disp_locked", 64'(locked), 1);
    $display("txn disperr: code_err_cnt=%0d err_cnt=%0d", code_cnt, err_cnt);

    // clear wins over same-cycle increment
    send_c(c, 1'b1, 1'b1); c = c + 16'd1;
    #1 chk("clr_err_cnt", 64'(err_cnt), 0);
    chk("clr_code_cnt", 64'(code_cnt), 0);
    chk("clr_word_cnt", 64'(word_cnt), 0);
    chk("clr_loss_cnt", 64'(loss_cnt), 0);
    $display("txn clear: counters checked");

    // enable low one cycle drops lock silently, relock at next frame
    send_c(c, 1'b0, 1'b0); c = c + 16'd1;
    #1 chk("en_low_locked", 64'(locked), 0);
    chk("en_low_err", 64'(err), 0);
    stream(13);
    #1 chk("en_relock", 64'(locked), 1);
    chk("en_word_cnt", 64'(word_cnt), 0);
    chk("en_loss_cnt", 64'(loss_cnt), 0);
    $display("txn en_low: relocked=%0b", locked);

    // single corrupted word 0x0123
    send_c(c, 1'b0, 1'b1);
    c = 16'h0100;
    stream(16'h23);
    drive(16'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0); c = c + 16'd1;
    stream(1);
    #1 chk("single_err_before", 64'(err), 0);
    stream(1);
    #1 chk("single_err_pulse", 64'(err), 1);
    stream(1);
    #1 chk("single_err_after", 64'(err), 0);
    chk("single_err_cnt", 64'(err_cnt), 1);
    chk("single_locked", 64'(locked), 1);
    stream(9);
    $display("txn single_err: err_cnt=%0d", err_cnt);

    // four bad words lose lock, relock at next comma plus seed
    repeat (4) begin
      drive(16'h5555, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0); c = c + 16'd1;
    end
    stream(2);
    #1 chk("loss_locked", 64'(locked), 0);
    chk("loss_cnt", 64'(loss_cnt), 1);
    chk("loss_err_cnt", 64'(err_cnt), 5);
    stream(14);
    #1 chk("loss_relock", 64'(locked), 1);
    $display("txn lock_loss: lock_loss_cnt=%0d", loss_cnt);

    // counter wrap 0xFFFF -> comma 0x0000 -> 0x0001
    send_c(c, 1'b0, 1'b0);
    c = 16'hFFE0;
    stream(49);
    #1 chk("wrap_err_cnt", 64'(err_cnt), 5);
    chk("wrap_loss_cnt", 64'(loss_cnt), 1);
    chk("wrap_locked", 64'(locked), 1);
    $display("txn wrap: locked=%0b err_cnt=%0d", locked, err_cnt);

    // asynchronous reset mid-frame
    stream(4);
    #2 rst_n = 1'b0;
    #1 all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    stream(14);
    #1 chk("rst_no_lock", 64'(locked), 0);
    stream(1);
    #1 chk("rst_relock", 64'(locked), 1);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    $display("txn async_reset: relocked=%0b", locked);

    // saturation of a narrow counter
    @(negedge clk) s_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("sat_hold", 64'(s_cnt), 7);
    @(negedge clk) s_clr = 1'b1;
    @(posedge clk);
    #1 chk("sat_clr", 64'(s_cnt), 0);
    @(negedge clk) s_clr = 1'b0;
    @(posedge clk);
    #1 chk("sat_after_clr", 64'(s_cnt), 1);
    s_inc = 1'b0;
    $display("txn saturate: cnt=%0d", s_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
